// File: rtl/dsp.sv
// dsp: 18x18 unsigned multiplier with optional D+/-B pre-adder and 48-bit post-adder; optional pre-adder under `DSP_PREADDER_EN`.
// Latency: A/B to P is 3 clocks with default parameters (A1/B1, M, P); D to P is 4 clocks through the pre-adder.
// Backpressure: none; each stage advances only when its CE is high, otherwise it holds.

module dsp_stage #(
    parameter int W  = 18,
    parameter bit EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb data_d = ce ? din : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    // Bypassed stages keep the flop so enable/reset ports stay connected; it is pruned in synthesis.
    assign dout = EN ? data_q : din;
endmodule

module dsp #(
    parameter int A0REG       = 0,
    parameter int A1REG       = 1,
    parameter int B0REG       = 0,
    parameter int B1REG       = 1,
    parameter int CREG        = 1,
    parameter int DREG        = 1,
    parameter int MREG        = 1,
    parameter int PREG        = 1,
    parameter int CARRYINREG  = 1,
    parameter int CARRYOUTREG = 1,
    parameter int OPMODEREG   = 1,
    parameter     CARRYINSEL  = "OPMODE5"
) (
    input  logic        CLK,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTCARRYIN,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTOPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CECARRYIN,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CEOPMODE,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    input  logic [7:0]  OPMODE,
    output logic [35:0] M,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic [17:0] BCOUT,
    output logic        CARRYOUT,
    output logic        CARRYOUTF
);
    localparam bit CIN_OPMODE5 = (CARRYINSEL == "OPMODE5");
    localparam bit CIN_EXT     = (CARRYINSEL == "CARRYIN");

    logic [17:0] a0_r, a1_r, b0_r, b1_in, b1_r, d_r;
    logic [47:0] c_r, p_r;
    logic [35:0] m_r;
    logic [7:0]  opmode_r;
    logic        cin_src, cin_r, carryout_r;
    logic [47:0] x_mux, z_mux;
    logic [48:0] post_sum;

    dsp_stage #(.W(8),  .EN(OPMODEREG != 0)) u_opmode (.clk(CLK), .rst_n(RSTOPMODE), .ce(CEOPMODE), .din(OPMODE), .dout(opmode_r));
    dsp_stage #(.W(18), .EN(A0REG != 0))     u_a0     (.clk(CLK), .rst_n(RSTA), .ce(CEA), .din(A),     .dout(a0_r));
    dsp_stage #(.W(18), .EN(A1REG != 0))     u_a1     (.clk(CLK), .rst_n(RSTA), .ce(CEA), .din(a0_r),  .dout(a1_r));
    dsp_stage #(.W(18), .EN(B0REG != 0))     u_b0     (.clk(CLK), .rst_n(RSTB), .ce(CEB), .din(B),     .dout(b0_r));
    dsp_stage #(.W(18), .EN(B1REG != 0))     u_b1     (.clk(CLK), .rst_n(RSTB), .ce(CEB), .din(b1_in), .dout(b1_r));
    dsp_stage #(.W(48), .EN(CREG != 0))      u_c      (.clk(CLK), .rst_n(RSTC), .ce(CEC), .din(C),     .dout(c_r));
    dsp_stage #(.W(18), .EN(DREG != 0))      u_d      (.clk(CLK), .rst_n(RSTD), .ce(CED), .din(D),     .dout(d_r));

`ifdef DSP_PREADDER_EN
    always_comb begin
        b1_in = b0_r;
        if (opmode_r[4]) b1_in = opmode_r[6] ? (d_r - b0_r) : (d_r + b0_r);
    end
`else
    logic unused_preadd;
    assign unused_preadd = ^{d_r[17:12], opmode_r[6], opmode_r[4]};
    always_comb b1_in = b0_r;
`endif

    dsp_stage #(.W(36), .EN(MREG != 0)) u_m (.clk(CLK), .rst_n(RSTM), .ce(CEM), .din(a1_r * b1_r), .dout(m_r));

    always_comb cin_src = CIN_OPMODE5 ? opmode_r[5] : (CIN_EXT ? CARRYIN : 1'b0);

    dsp_stage #(.W(1), .EN(CARRYINREG != 0)) u_cin (.clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .din(cin_src), .dout(cin_r));

    always_comb begin
        x_mux = '0;
        z_mux = '0;
        case (opmode_r[1:0])
            2'd1:    x_mux = {12'd0, m_r};
            2'd2:    x_mux = p_r;
            2'd3:    x_mux = {d_r[11:0], a1_r, b1_r};
            default: x_mux = '0;
        endcase
        case (opmode_r[3:2])
            2'd1:    z_mux = PCIN;
            2'd2:    z_mux = p_r;
            2'd3:    z_mux = c_r;
            default: z_mux = '0;
        endcase
        // Bit 48 of the 49-bit result is the carry (or borrow when subtracting).
        if (opmode_r[7]) post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin_r});
        else             post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin_r};
    end

    dsp_stage #(.W(48), .EN(PREG != 0))       u_p  (.clk(CLK), .rst_n(RSTP), .ce(CEP), .din(post_sum[47:0]), .dout(p_r));
    dsp_stage #(.W(1),  .EN(CARRYOUTREG != 0)) u_co (.clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .din(post_sum[48]), .dout(carryout_r));

    assign M         = m_r;
    assign P         = p_r;
    assign PCOUT     = p_r;
    assign BCOUT     = b1_r;
    assign CARRYOUT  = carryout_r;
    assign CARRYOUTF = carryout_r;
endmodule

// File: tb/tb_dsp.sv
// Directed bench for dsp: reset state, streaming latency, mux/adder modes, async P reset and CEP hold.
`timescale 1ns/1ps
module tb_dsp;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RSTA, RSTB, RSTC, RSTD, RSTCARRYIN, RSTM, RSTP, RSTOPMODE;
    logic CEA, CEB, CEC, CED, CECARRYIN, CEM, CEP, CEOPMODE;
    logic [17:0] A, B, D;
    logic [47:0] C, PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic [17:0] BCOUT;
    logic        CARRYOUT, CARRYOUTF;

    dsp dut (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
        .RSTCARRYIN(RSTCARRYIN), .RSTM(RSTM), .RSTP(RSTP), .RSTOPMODE(RSTOPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CECARRYIN(CECARRYIN),
        .CEM(CEM), .CEP(CEP), .CEOPMODE(CEOPMODE),
        .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .M(M), .P(P), .PCOUT(PCOUT), .BCOUT(BCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    typedef struct {
        logic [47:0] p;
        logic        co;
    } exp_t;

    exp_t        sb_q[$];
    logic [35:0] exp_m_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [47:0] p, input logic co);
        exp_t e;
        e.p  = p;
        e.co = co;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag, input bit with_co);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_p"}, P, e.p);
            check({tag, "_pcout"}, PCOUT, e.p);
            if (with_co) begin
                check({tag, "_co"}, {47'd0, CARRYOUT}, {47'd0, e.co});
                check({tag, "_cof"}, {47'd0, CARRYOUTF}, {47'd0, e.co});
            end
        end
    endtask

    task automatic set_rst(input logic v);
        {RSTA, RSTB, RSTC, RSTD, RSTCARRYIN, RSTM, RSTP, RSTOPMODE} = {8{v}};
    endtask

    initial begin
        logic [17:0] a_v, b_v, bc_exp;
        logic [35:0] prod;
        logic [35:0] em;
        logic [47:0] cat_exp, p17_exp;
        exp_t e;

        set_rst(1'b0);
        {CEA, CEB, CEC, CED, CECARRYIN, CEM, CEP, CEOPMODE} = 8'hFF;
        A = 18'd3; B = 18'd5; D = 18'd10; C = 48'd100; PCIN = 48'd0;
        CARRYIN = 1'b0; OPMODE = 8'h01;
        repeat (2) @(negedge CLK);
        check("rst_m",     {12'd0, M}, 48'd0);
        check("rst_p",     P, 48'd0);
        check("rst_pcout", PCOUT, 48'd0);
        check("rst_bcout", {30'd0, BCOUT}, 48'd0);
        check("rst_co",    {47'd0, CARRYOUT}, 48'd0);
        check("rst_cof",   {47'd0, CARRYOUTF}, 48'd0);

        set_rst(1'b1);

        // Fresh operands every cycle: M appears 2 clocks later, P 3 clocks later.
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            if (k >= 3) begin
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("stream_p", P, e.p);
                end
            end
            if (k >= 2 && k < 8) begin
                if (exp_m_q.size() != 0) begin
                    em = exp_m_q.pop_front();
                    check("stream_m", {12'd0, M}, {12'd0, em});
                end
            end
            if (k < 6) begin
                a_v  = 18'($urandom_range(0, 262143));
                b_v  = 18'($urandom_range(0, 262143));
                A    = a_v;
                B    = b_v;
                prod = 36'(a_v) * 36'(b_v);
                push_exp({12'd0, prod}, 1'b0);
                exp_m_q.push_back(prod);
            end
        end

        A = 18'd3; B = 18'd5; OPMODE = 8'h01;
        push_exp(48'd15, 1'b0);
        repeat (3) @(negedge CLK);
        check("lat3_m", {12'd0, M}, 48'd15);
        pop_check("lat3", 1'b0);

`ifdef DSP_PREADDER_EN
        p17_exp = 48'd12; bc_exp = 18'd6;
`else
        p17_exp = 48'd8;  bc_exp = 18'd4;
`endif
        D = 18'd10; B = 18'd4; A = 18'd2; OPMODE = 8'h51;
        push_exp(p17_exp, 1'b0);
        repeat (6) @(negedge CLK);
        pop_check("preadd", 1'b1);
        check("preadd_bcout", {30'd0, BCOUT}, {30'd0, bc_exp});

        A = 18'd2; B = 18'd3; C = 48'd100; OPMODE = 8'h2D;
        push_exp(48'd107, 1'b0);
        repeat (6) @(negedge CLK);
        pop_check("add_cin", 1'b1);

        OPMODE = 8'h8D;
        push_exp(48'd94, 1'b0);
        repeat (6) @(negedge CLK);
        pop_check("sub", 1'b1);

        C = 48'd0;
        push_exp(48'hFFFF_FFFF_FFFA, 1'b1);
        repeat (6) @(negedge CLK);
        pop_check("sub_wrap", 1'b1);

        C = 48'hFFFF_FFFF_FFFF; A = 18'd1; B = 18'd1; OPMODE = 8'h0D;
        push_exp(48'd0, 1'b1);
        repeat (6) @(negedge CLK);
        pop_check("add_wrap", 1'b1);

        D = 18'h00ABC; A = 18'h12345; B = 18'h2ABCD; OPMODE = 8'h03;
        cat_exp = {12'hABC, 18'h12345, 18'h2ABCD};
        push_exp(cat_exp, 1'b0);
        repeat (6) @(negedge CLK);
        pop_check("x_concat", 1'b1);

        PCIN = 48'd1000; A = 18'd3; B = 18'd5; OPMODE = 8'h05;
        push_exp(48'd1015, 1'b0);
        repeat (6) @(negedge CLK);
        pop_check("z_pcin", 1'b1);

        OPMODE = 8'h01;
        push_exp(48'd15, 1'b0);
        repeat (6) @(negedge CLK);
        pop_check("pre_rstp", 1'b0);

        // RSTP asserted between edges must clear P without waiting for a clock.
        @(negedge CLK);
        #2 RSTP = 1'b0;
        #1;
        check("rstp_async_p", P, 48'd0);
        check("rstp_async_pcout", PCOUT, 48'd0);
        @(negedge CLK);
        RSTP = 1'b1;
        push_exp(48'd15, 1'b0);
        repeat (3) @(negedge CLK);
        pop_check("post_rstp", 1'b0);

        CEP = 1'b0; A = 18'd7; B = 18'd9;
        push_exp(48'd15, 1'b0);
        repeat (6) @(negedge CLK);
        pop_check("cep_hold", 1'b0);
        CEP = 1'b1;
        push_exp(48'd63, 1'b0);
        repeat (2) @(negedge CLK);
        pop_check("cep_resume", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
